memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes the two execute results (r1, r2), the condition result (cres) and the mem_op passthrough fields (two addresses, two 4-bit memory ops).
- Performs up to two sequential word/half/byte accesses on a req/ack data bus, then forwards the results and the reg_wb fields to writeback.
- Stalls upstream via in_ready while bus accesses are outstanding.

---
 rtl/memory_stage_pkg.sv | 60 ++++++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/memory_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: memory op codes, FSM states and op decode helpers.
package mem_stage_defs;

    localparam logic [3:0] MOP_NONE = 4'd0;
    localparam logic [3:0] MOP_LDW  = 4'd1;
    localparam logic [3:0] MOP_LDH  = 4'd2;
    localparam logic [3:0] MOP_LDHS = 4'd3;
    localparam logic [3:0] MOP_LDB  = 4'd4;
    localparam logic [3:0] MOP_LDBS = 4'd5;
    localparam logic [3:0] MOP_STW  = 4'd6;
    localparam logic [3:0] MOP_STH  = 4'd7;
    localparam logic [3:0] MOP_STB  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic  is_load;
        logic  is_store;
        logic  sign_ext;
        size_t size;
    } mop_info_t;

    function automatic logic mop_is_load(input logic [3:0] op);
        return op inside {MOP_LDW, MOP_LDH, MOP_LDHS, MOP_LDB, MOP_LDBS};
    endfunction

    function automatic logic mop_is_store(input logic [3:0] op);
        return op inside {MOP_STW, MOP_STH, MOP_STB};
    endfunction

    // Codes 9..15 decode as inactive, same as NONE.
    function automatic logic mop_active(input logic [3:0] op);
        return mop_is_load(op) | mop_is_store(op);
    endfunction

    function automatic mop_info_t mop_decode(input logic [3:0] op);
        mop_info_t info;
        info          = '0;
        info.is_load  = mop_is_load(op);
        info.is_store = mop_is_store(op);
        info.sign_ext = (op == MOP_LDHS) || (op == MOP_LDBS);
        case (op)
            MOP_LDW, MOP_STW:           info.size = SZ_WORD;
            MOP_LDH, MOP_LDHS, MOP_STH: info.size = SZ_HALF;
            default:                    info.size = SZ_BYTE;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, lane-replicated store data,
// extended load data and alignment check for one access.
module mem_lane_align
    import mem_stage_defs::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misaligned
);

    mop_info_t  info;
    logic [7:0] lane_byte [4];
    logic [7:0] sel_byte;
    logic [15:0] sel_half;

    assign info = mop_decode(op);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        be         = 4'b0000;
        wdata      = 32'd0;
        ldata      = 32'd0;
        misaligned = 1'b0;
        sel_byte   = lane_byte[addr_lo];
        sel_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        if (info.is_load || info.is_store) begin
            case (info.size)
                SZ_WORD: begin
                    be         = 4'b1111;
                    wdata      = sdata;
                    ldata      = rdata;
                    misaligned = |addr_lo;
                end
                SZ_HALF: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata      = {2{sdata[15:0]}};
                    ldata      = {{16{info.sign_ext & sel_half[15]}}, sel_half};
                    misaligned = addr_lo[0];
                end
                default: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{sdata[7:0]}};
                    ldata = {{24{info.sign_ext & sel_byte[7]}}, sel_byte};
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: up to two sequential bus accesses per accepted
// execute result, then a one-cycle result strobe towards writeback.
module memory_stage
    import mem_stage_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic        cres,
    input  logic [31:0] m_a1,
    input  logic [31:0] m_a2,
    input  logic [3:0]  m_r1_op,
    input  logic [3:0]  m_r2_op,
    input  logic [4:0]  r_a1,
    input  logic [4:0]  r_a2,
    input  logic [3:0]  r_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] q1,
    output logic [31:0] q2,
    output logic        qcres,
    output logic [4:0]  qr_a1,
    output logic [4:0]  qr_a2,
    output logic [3:0]  qr_op,
    output logic        misalign,
    output logic        bus_err
);

    state_t      state_reg, state_next;
    logic [3:0]  op1_reg, op1_next, op2_reg, op2_next;
    logic [31:0] a1_reg, a1_next, a2_reg, a2_next;
    logic [31:0] res1_reg, res1_next, res2_reg, res2_next;
    logic        cres_reg, cres_next;
    logic [4:0]  ra1_reg, ra1_next, ra2_reg, ra2_next;
    logic [3:0]  rop_reg, rop_next;
    logic        mis_reg, mis_next, err_reg, err_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        final_fire;

    logic        out_valid_reg, qcres_reg, misalign_reg, bus_err_reg;
    logic [31:0] q1_reg, q2_reg;
    logic [4:0]  qr_a1_reg, qr_a2_reg;
    logic [3:0]  qr_op_reg;

    logic        in_op, cur_is_op2;
    logic [3:0]  cur_op;
    logic [31:0] cur_addr, cur_sdata, lane_ldata, slot_res;
    logic        lane_mis, timed_out, slot_done, slot_timeout;

    assign in_op      = (state_reg != ST_IDLE);
    assign cur_is_op2 = (state_reg == ST_OP2);
    assign cur_op     = cur_is_op2 ? op2_reg  : op1_reg;
    assign cur_addr   = cur_is_op2 ? a2_reg   : a1_reg;
    // The slot result register still holds the original r value while its access runs.
    assign cur_sdata  = cur_is_op2 ? res2_reg : res1_reg;

    mem_lane_align u_align (
        .op         (cur_op),
        .addr_lo    (cur_addr[1:0]),
        .sdata      (cur_sdata),
        .rdata      (mem_rdata),
        .be         (mem_be),
        .wdata      (mem_wdata),
        .ldata      (lane_ldata),
        .misaligned (lane_mis)
    );

    assign in_ready     = (state_reg == ST_IDLE);
    assign mem_req      = in_op && !lane_mis;
    assign mem_we       = mop_is_store(cur_op);
    assign mem_addr     = {cur_addr[31:2], 2'b00};
    assign timed_out    = (TIMEOUT_CYCLES != 0) && (cnt_reg == TIMEOUT_CYCLES);
    assign slot_done    = in_op && (lane_mis || mem_ack || timed_out);
    assign slot_timeout = timed_out && !mem_ack && !lane_mis;
    assign slot_res     = (mem_ack && !lane_mis && mop_is_load(cur_op)) ? lane_ldata : cur_sdata;

    always_comb begin
        state_next = state_reg;
        op1_next   = op1_reg;
        op2_next   = op2_reg;
        a1_next    = a1_reg;
        a2_next    = a2_reg;
        res1_next  = res1_reg;
        res2_next  = res2_reg;
        cres_next  = cres_reg;
        ra1_next   = ra1_reg;
        ra2_next   = ra2_reg;
        rop_next   = rop_reg;
        mis_next   = mis_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg + 32'd1;
        final_fire = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = 32'd0;
                if (in_valid) begin
                    op1_next  = m_r1_op;
                    op2_next  = m_r2_op;
                    a1_next   = m_a1;
                    a2_next   = m_a2;
                    res1_next = r1;
                    res2_next = r2;
                    cres_next = cres;
                    ra1_next  = r_a1;
                    ra2_next  = r_a2;
                    rop_next  = r_op;
                    mis_next  = 1'b0;
                    err_next  = 1'b0;
                    if (cres && mop_active(m_r1_op)) begin
                        state_next = ST_OP1;
                    end else if (cres && mop_active(m_r2_op)) begin
                        state_next = ST_OP2;
                    end else begin
                        final_fire = 1'b1;
                    end
                end
            end
            ST_OP1: begin
                if (slot_done) begin
                    cnt_next  = 32'd0;
                    res1_next = slot_res;
                    mis_next  = mis_reg | lane_mis;
                    err_next  = err_reg | slot_timeout;
                    if (mop_active(op2_reg)) begin
                        state_next = ST_OP2;
                    end else begin
                        state_next = ST_IDLE;
                        final_fire = 1'b1;
                    end
                end
            end
            ST_OP2: begin
                if (slot_done) begin
                    cnt_next   = 32'd0;
                    res2_next  = slot_res;
                    mis_next   = mis_reg | lane_mis;
                    err_next   = err_reg | slot_timeout;
                    state_next = ST_IDLE;
                    final_fire = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            op1_reg       <= MOP_NONE;
            op2_reg       <= MOP_NONE;
            a1_reg        <= 32'd0;
            a2_reg        <= 32'd0;
            res1_reg      <= 32'd0;
            res2_reg      <= 32'd0;
            cres_reg      <= 1'b0;
            ra1_reg       <= 5'd0;
            ra2_reg       <= 5'd0;
            rop_reg       <= 4'd0;
            mis_reg       <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= 32'd0;
            out_valid_reg <= 1'b0;
            q1_reg        <= 32'd0;
            q2_reg        <= 32'd0;
            qcres_reg     <= 1'b0;
            qr_a1_reg     <= 5'd0;
            qr_a2_reg     <= 5'd0;
            qr_op_reg     <= 4'd0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op1_reg       <= op1_next;
            op2_reg       <= op2_next;
            a1_reg        <= a1_next;
            a2_reg        <= a2_next;
            res1_reg      <= res1_next;
            res2_reg      <= res2_next;
            cres_reg      <= cres_next;
            ra1_reg       <= ra1_next;
            ra2_reg       <= ra2_next;
            rop_reg       <= rop_next;
            mis_reg       <= mis_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= final_fire;
            if (final_fire) begin
                q1_reg       <= res1_next;
                q2_reg       <= res2_next;
                qcres_reg    <= cres_next;
                qr_a1_reg    <= ra1_next;
                qr_a2_reg    <= ra2_next;
                qr_op_reg    <= rop_next;
                misalign_reg <= mis_next;
                bus_err_reg  <= err_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign q1        = q1_reg;
    assign q2        = q2_reg;
    assign qcres     = qcres_reg;
    assign qr_a1     = qr_a1_reg;
    assign qr_a2     = qr_a2_reg;
    assign qr_op     = qr_op_reg;
    assign misalign  = misalign_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: small bus responder per transaction and
// hand-computed expectations for results, bus fields, latency and flags.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] r1, r2, m_a1, m_a2;
    logic        cres;
    logic [3:0]  m_r1_op, m_r2_op, r_op;
    logic [4:0]  r_a1, r_a2;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        out_valid, qcres, misalign, bus_err;
    logic [31:0] q1, q2;
    logic [4:0]  qr_a1, qr_a2;
    logic [3:0]  qr_op;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .r1(r1), .r2(r2), .cres(cres), .m_a1(m_a1), .m_a2(m_a2),
        .m_r1_op(m_r1_op), .m_r2_op(m_r2_op), .r_a1(r_a1), .r_a2(r_a2), .r_op(r_op),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .q1(q1), .q2(q2), .qcres(qcres),
        .qr_a1(qr_a1), .qr_a2(qr_a2), .qr_op(qr_op), .misalign(misalign), .bus_err(bus_err)
    );

    int checks = 0;
    int errors = 0;

    int          lat, req_cnt;
    logic        req_at_ov;
    int          ack_dly [2];
    logic [31:0] rd [2];
    logic [31:0] cap_addr [2];
    logic [31:0] cap_wdata [2];
    logic [3:0]  cap_be [2];
    logic        cap_we [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input string name, input logic c,
                           input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] v1,
                           input logic [3:0] o2, input logic [31:0] a2, input logic [31:0] v2,
                           input logic [4:0] ra1, input logic [4:0] ra2, input logic [3:0] rop);
        int   reqi, wt;
        logic seen, acked, was_req;
        @(posedge clk); #1;
        check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
        cres = c; m_r1_op = o1; m_a1 = a1; r1 = v1;
        m_r2_op = o2; m_a2 = a2; r2 = v2;
        r_a1 = ra1; r_a2 = ra2; r_op = rop;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; req_cnt = 0; seen = 1'b0; reqi = 0; wt = 0; req_at_ov = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            if (out_valid) begin
                seen = 1'b1;
                lat = cyc;
                req_at_ov = mem_req;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A5A5A;
                was_req   = mem_req;
                if (mem_req) begin
                    req_cnt++;
                    if (reqi < 2) begin
                        if (wt == 0) begin
                            cap_addr[reqi]  = mem_addr;
                            cap_wdata[reqi] = mem_wdata;
                            cap_be[reqi]    = mem_be;
                            cap_we[reqi]    = mem_we;
                        end
                        if (ack_dly[reqi] == wt) begin
                            mem_ack   = 1'b1;
                            mem_rdata = rd[reqi];
                        end
                    end
                end
                acked = mem_ack;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (acked) begin
                    reqi++;
                    wt = 0;
                end else if (was_req) begin
                    wt++;
                end else begin
                    wt = 0;
                end
            end
        end
        if (!seen) begin
            check_eq({name, "_out_valid_seen"}, 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            check_eq({name, "_ov_pulse"}, 32'(out_valid), 32'd0);
        end
        $display("TXN %s lat=%0d reqs=%0d q1=%h q2=%h qcres=%0d mis=%0d err=%0d",
                 name, lat, req_cnt, q1, q2, qcres, misalign, bus_err);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        r1 = 32'd0; r2 = 32'd0; cres = 1'b0; m_a1 = 32'd0; m_a2 = 32'd0;
        m_r1_op = 4'd0; m_r2_op = 4'd0; r_a1 = 5'd0; r_a2 = 5'd0; r_op = 4'd0;
        ack_dly[0] = 0; ack_dly[1] = 0; rd[0] = 32'd0; rd[1] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mem_req",   32'(mem_req),   32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_q1",        q1,             32'd0);
        check_eq("rst_q2",        q2,             32'd0);
        check_eq("rst_qcres",     32'(qcres),     32'd0);
        check_eq("rst_qr",        {18'd0, qr_a1, qr_a2, qr_op}, 32'd0);
        check_eq("rst_flags",     {30'd0, misalign, bus_err}, 32'd0);
        rst = 1'b1;

        // LDW, immediate ack
        ack_dly[0] = 0; rd[0] = 32'hDEADBEEF;
        run_txn("ldw", 1'b1, 4'd1, 32'h100, 32'h11111111, 4'd0, 32'h0, 32'h22222222, 5'd3, 5'd4, 4'h2);
        check_eq("ldw_lat",   32'(lat),     32'd2);
        check_eq("ldw_reqs",  32'(req_cnt), 32'd1);
        check_eq("ldw_addr",  cap_addr[0],  32'h100);
        check_eq("ldw_be",    32'(cap_be[0]), 32'hF);
        check_eq("ldw_we",    32'(cap_we[0]), 32'd0);
        check_eq("ldw_q1",    q1,           32'hDEADBEEF);
        check_eq("ldw_q2",    q2,           32'h22222222);
        check_eq("ldw_qcres", 32'(qcres),   32'd1);
        check_eq("ldw_qr",    {18'd0, qr_a1, qr_a2, qr_op}, {18'd0, 5'd3, 5'd4, 4'h2});
        check_eq("ldw_flags", {30'd0, misalign, bus_err}, 32'd0);

        // STB then LDBS
        ack_dly[0] = 0; ack_dly[1] = 0; rd[1] = 32'h00008000;
        run_txn("stb_ldbs", 1'b1, 4'd8, 32'h103, 32'h000000A5, 4'd5, 32'h101, 32'h33333333, 5'd1, 5'd2, 4'h1);
        check_eq("stb_lat",   32'(lat),       32'd3);
        check_eq("stb_reqs",  32'(req_cnt),   32'd2);
        check_eq("stb_be",    32'(cap_be[0]), 32'h8);
        check_eq("stb_wdata", cap_wdata[0],   32'hA5A5A5A5);
        check_eq("stb_we",    32'(cap_we[0]), 32'd1);
        check_eq("stb_addr",  cap_addr[0],    32'h100);
        check_eq("ldbs_be",   32'(cap_be[1]), 32'h2);
        check_eq("ldbs_we",   32'(cap_we[1]), 32'd0);
        check_eq("ldbs_addr", cap_addr[1],    32'h100);
        check_eq("stb_q1",    q1,             32'h000000A5);
        check_eq("ldbs_q2",   q2,             32'hFFFFFF80);

        // cres=0 suppresses the store
        run_txn("cres0", 1'b0, 4'd6, 32'h40, 32'h77777777, 4'd1, 32'h44, 32'h88888888, 5'd7, 5'd8, 4'h3);
        check_eq("cres0_lat",   32'(lat),     32'd1);
        check_eq("cres0_reqs",  32'(req_cnt), 32'd0);
        check_eq("cres0_qcres", 32'(qcres),   32'd0);
        check_eq("cres0_q1",    q1,           32'h77777777);
        check_eq("cres0_q2",    q2,           32'h88888888);
        check_eq("cres0_qr",    {18'd0, qr_a1, qr_a2, qr_op}, {18'd0, 5'd7, 5'd8, 4'h3});

        // misaligned LDH skipped, LDW performed
        ack_dly[0] = 0; rd[0] = 32'h01020304;
        run_txn("mis", 1'b1, 4'd2, 32'h201, 32'h44444444, 4'd1, 32'h204, 32'h99999999, 5'd0, 5'd0, 4'h0);
        check_eq("mis_lat",  32'(lat),     32'd3);
        check_eq("mis_reqs", 32'(req_cnt), 32'd1);
        check_eq("mis_addr", cap_addr[0],  32'h204);
        check_eq("mis_flag", 32'(misalign), 32'd1);
        check_eq("mis_err",  32'(bus_err), 32'd0);
        check_eq("mis_q1",   q1,           32'h44444444);
        check_eq("mis_q2",   q2,           32'h01020304);

        // timeout with TIMEOUT_CYCLES=4
        ack_dly[0] = -1;
        run_txn("tmo", 1'b1, 4'd1, 32'h400, 32'h55555555, 4'd0, 32'h0, 32'h0, 5'd0, 5'd0, 4'h0);
        check_eq("tmo_reqs",   32'(req_cnt),   32'd5);
        check_eq("tmo_lat",    32'(lat),       32'd6);
        check_eq("tmo_req_dn", 32'(req_at_ov), 32'd0);
        check_eq("tmo_err",    32'(bus_err),   32'd1);
        check_eq("tmo_mis",    32'(misalign),  32'd0);
        check_eq("tmo_q1",     q1,             32'h55555555);

        // STH with 2 wait cycles, then LDHS upper half
        ack_dly[0] = 2; ack_dly[1] = 0; rd[1] = 32'h80011234;
        run_txn("sth_ldhs", 1'b1, 4'd7, 32'h302, 32'h1234ABCD, 4'd3, 32'h302, 32'h66666666, 5'd9, 5'd10, 4'h4);
        check_eq("sth_lat",   32'(lat),       32'd5);
        check_eq("sth_reqs",  32'(req_cnt),   32'd4);
        check_eq("sth_be",    32'(cap_be[0]), 32'hC);
        check_eq("sth_wdata", cap_wdata[0],   32'hABCDABCD);
        check_eq("sth_addr",  cap_addr[0],    32'h300);
        check_eq("ldhs_be",   32'(cap_be[1]), 32'hC);
        check_eq("sth_q1",    q1,             32'h1234ABCD);
        check_eq("ldhs_q2",   q2,             32'hFFFF8001);
        check_eq("sth_err",   32'(bus_err),   32'd0);

        // LDB lane 2 with 1 wait, then STW
        ack_dly[0] = 1; ack_dly[1] = 0; rd[0] = 32'h00AB0000;
        run_txn("ldb_stw", 1'b1, 4'd4, 32'h002, 32'hBBBBBBBB, 4'd6, 32'h008, 32'hCAFEF00D, 5'd0, 5'd0, 4'h0);
        check_eq("ldb_lat",   32'(lat),       32'd4);
        check_eq("ldb_reqs",  32'(req_cnt),   32'd3);
        check_eq("ldb_be",    32'(cap_be[0]), 32'h4);
        check_eq("stw_be",    32'(cap_be[1]), 32'hF);
        check_eq("stw_wdata", cap_wdata[1],   32'hCAFEF00D);
        check_eq("stw_we",    32'(cap_we[1]), 32'd1);
        check_eq("stw_addr",  cap_addr[1],    32'h008);
        check_eq("ldb_q1",    q1,             32'h000000AB);
        check_eq("stw_q2",    q2,             32'hCAFEF00D);

        // back-to-back zero-op accepts
        @(posedge clk); #1;
        cres = 1'b1; m_r1_op = 4'd0; m_r2_op = 4'd0; r1 = 32'hA0A0A0A0; r2 = 32'h1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("b2b_ov1",   32'(out_valid), 32'd1);
        check_eq("b2b_q1a",   q1,             32'hA0A0A0A0);
        check_eq("b2b_rdy",   32'(in_ready),  32'd1);
        r1 = 32'hB0B0B0B0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("b2b_ov2",   32'(out_valid), 32'd1);
        check_eq("b2b_q1b",   q1,             32'hB0B0B0B0);
        @(posedge clk); #1;
        check_eq("b2b_ov3",   32'(out_valid), 32'd0);
        $display("TXN b2b q1=%h", q1);

        // reset during OP1, late ack ignored
        @(posedge clk); #1;
        cres = 1'b1; m_r1_op = 4'd1; m_a1 = 32'h500; r1 = 32'hEEEEEEEE; m_r2_op = 4'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("rst6_req_on", 32'(mem_req), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst6_req_off", 32'(mem_req),   32'd0);
        check_eq("rst6_ov",      32'(out_valid), 32'd0);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check_eq("rst6_req_post", 32'(mem_req),   32'd0);
        check_eq("rst6_ready",    32'(in_ready),  32'd1);
        check_eq("rst6_ov_post",  32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("rst6_ov_late",  32'(out_valid), 32'd0);
        check_eq("rst6_q1",       q1,             32'd0);
        $display("TXN reset_mid_access req=%0d ready=%0d", mem_req, in_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
